// File: rtl/proc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : proc_ctrl_fsm
// Purpose  : Control unit for the simple 9-bit processor datapath. Each
//            instruction runs through time steps T0..T3. The unit drives the
//            one-hot register-file enables, the A/G/IR load strobes, the bus
//            source selects and the ALU add/sub select.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SEL_W   register-select field width (NREG = 2**SEL_W, IR = 3+2*SEL_W bits)
// Ports
//   Clock   in   1          system clock, rising-edge active
//   Reset   in   1          synchronous active-high reset
//   Run     in   1          start request, sampled only in T0
//   IR      in   3+2*SEL_W  instruction, fields III XXX YYY
//   GNZ     in   1          G non-zero flag (used only by mvnz)
//   IRin    out  1          load IR from DIN
//   Rin     out  [0:NREG-1] one-hot register load enables (bit 0 = R0)
//   Rout    out  [0:NREG-1] one-hot register bus-drive enables (bit 0 = R0)
//   Ain     out  1          load A from bus
//   Gin     out  1          load G from ALU
//   Gout    out  1          G drives bus
//   DINout  out  1          DIN drives bus
//   AddSub  out  1          ALU select, 0 = add, 1 = subtract
//   Done    out  1          final step of an instruction
// Build option
//   PROC_CTRL_MVNZ_EN  when defined, opcode 100 is mvnz Rx,Ry (conditional
//                      move on GNZ); otherwise opcode 100 is a NOP and GNZ
//                      is ignored.
// ============================================================================
module proc_ctrl_fsm #(
  parameter int SEL_W = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Run,
  input  logic [3+2*SEL_W-1:0]   IR,
  input  logic                   GNZ,
  output logic                   IRin,
  output logic [0:(2**SEL_W)-1]  Rin,
  output logic [0:(2**SEL_W)-1]  Rout,
  output logic                   Ain,
  output logic                   Gin,
  output logic                   Gout,
  output logic                   DINout,
  output logic                   AddSub,
  output logic                   Done
);

  localparam int NREG = 2**SEL_W;
  localparam int IRW  = 3 + 2*SEL_W;

  localparam logic [2:0] c_OP_MV  = 3'b000;
  localparam logic [2:0] c_OP_MVI = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_SUB = 3'b011;
`ifdef PROC_CTRL_MVNZ_EN
  localparam logic [2:0] c_OP_MVNZ = 3'b100;
`endif

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } step_t;

  step_t r_step;
  step_t w_step_next;

  logic [2:0]       w_opcode;
  logic [SEL_W-1:0] w_x;
  logic [SEL_W-1:0] w_y;
  logic             w_is_alu;

  assign w_opcode = IR[IRW-1 -: 3];
  assign w_x      = IR[2*SEL_W-1 -: SEL_W];
  assign w_y      = IR[SEL_W-1:0];
  assign w_is_alu = (w_opcode == c_OP_ADD) || (w_opcode == c_OP_SUB);

`ifndef PROC_CTRL_MVNZ_EN
  // GNZ only matters for mvnz; keep it visibly consumed in this build.
  logic w_unused_gnz;
  assign w_unused_gnz = GNZ;
`endif

  // Enable-gated N-to-2**N decoder: one-hot on sel when en, else all zero.
  function automatic logic [0:NREG-1] dec(input logic [SEL_W-1:0] sel,
                                          input logic             en);
    logic [0:NREG-1] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (en && (sel == SEL_W'(i))) v[i] = 1'b1;
    end
    return v;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) r_step <= T0;
    else       r_step <= w_step_next;
  end

  always_comb begin
    w_step_next = T0;
    IRin        = 1'b0;
    Rin         = '0;
    Rout        = '0;
    Ain         = 1'b0;
    Gin         = 1'b0;
    Gout        = 1'b0;
    DINout      = 1'b0;
    AddSub      = 1'b0;
    Done        = 1'b0;

    case (r_step)
      T0: begin
        IRin        = Run;
        w_step_next = Run ? T1 : T0;
      end
      T1: begin
        w_step_next = T0;
        case (w_opcode)
          c_OP_MV: begin
            Rout = dec(w_y, 1'b1);
            Rin  = dec(w_x, 1'b1);
            Done = 1'b1;
          end
          c_OP_MVI: begin
            DINout = 1'b1;
            Rin    = dec(w_x, 1'b1);
            Done   = 1'b1;
          end
          c_OP_ADD, c_OP_SUB: begin
            Rout        = dec(w_x, 1'b1);
            Ain         = 1'b1;
            w_step_next = T2;
          end
`ifdef PROC_CTRL_MVNZ_EN
          c_OP_MVNZ: begin
            // The move happens only when G is non-zero; Done regardless.
            Rout = dec(w_y, GNZ);
            Rin  = dec(w_x, GNZ);
            Done = 1'b1;
          end
`endif
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        // Only ALU ops reach T2; anything else falls back to T0.
        if (w_is_alu) begin
          Rout        = dec(w_y, 1'b1);
          Gin         = 1'b1;
          AddSub      = w_opcode[0];
          w_step_next = T3;
        end
      end
      T3: begin
        if (w_is_alu) begin
          Gout = 1'b1;
          Rin  = dec(w_x, 1'b1);
          Done = 1'b1;
        end
      end
      default: w_step_next = T0;
    endcase

    // Reset suppresses every strobe so an aborted instruction writes nothing.
    if (Reset) begin
      IRin   = 1'b0;
      Rin    = '0;
      Rout   = '0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      Gout   = 1'b0;
      DINout = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
    end
  end

endmodule
`default_nettype wire
